dma_master_mc: RTL and testbench

Parametrised successor to the single-channel AXI-lite DMA master in this design. It copies `len` words from a source region to a destination region using decoupled read and write engines with an internal show-ahead FIFO. It adds configurable data, address and length widths, a configurable FIFO depth, and fixed or incrementing addressing per side, so it can drain from or fill peripheral FIFOs. It sits between the Tiny Tapeout control logic and a single AXI-lite slave port.

---
 rtl/dma_master_mc.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_dma_master_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : dma_master_mc
// Description : Parametrised AXI-lite DMA master. Copies len words from a
//               source region to a destination region using decoupled read
//               and write engines joined by a show-ahead FIFO. Each side can
//               use incrementing or fixed addressing.
//               Optional macro DMA_RESP_CHECK_EN: a nonzero RRESP/BRESP sets
//               error and aborts the transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_master_mc #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP
);

  localparam int C_BYTES = DATA_W / 8;
  localparam int C_SHIFT = $clog2(C_BYTES);
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [C_PTR_W:0] C_DEPTH = (C_PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_AR = 2'd1, RD_R = 2'd2} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_AWW = 2'd1, WR_B = 2'd2} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic              src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
  logic [LEN_W:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [C_PTR_W:0]   cnt_q, cnt_d;

  logic              w_start, w_push, w_pop, w_bhs, w_bad;
  logic [LEN_W:0]    w_len;
  logic [DATA_W-1:0] w_head;

  assign w_start = start & ~busy_q;
  assign w_push  = rready_q & RVALID;
  assign w_pop   = wvalid_q & WREADY;
  assign w_bhs   = bready_q & BVALID;
  assign w_len   = {1'b0, len_q};
  // When the FIFO is empty the word being pushed this cycle is the head.
  assign w_head  = (cnt_q == '0) ? RDATA : mem[rptr_q];

`ifdef DMA_RESP_CHECK_EN
  assign w_bad = (w_push && (RRESP != 2'b00)) || (w_bhs && (BRESP != 2'b00));
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{RRESP, BRESP};
  assign w_bad = 1'b0;
`endif

  // Word address: base plus count scaled to bytes, or the base when fixed.
  function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] base,
                                               input logic inc,
                                               input logic [LEN_W:0] cnt);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(cnt) << C_SHIFT;
    return inc ? (base + off) : base;
  endfunction

  // Next-state logic for the request latch, both engines, FIFO and completion.
  always_comb begin
    rd_state_d = rd_state_q;
    wr_state_d = wr_state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    len_d      = len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    src_inc_d  = src_inc_q;
    dst_inc_d  = dst_inc_q;
    rd_cnt_d   = rd_cnt_q + (LEN_W+1)'(w_push);
    wr_cnt_d   = wr_cnt_q + (LEN_W+1)'(w_bhs);
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    bready_d   = bready_q;
    wptr_d     = w_push ? wptr_q + C_PTR_W'(1) : wptr_q;
    rptr_d     = w_pop  ? rptr_q + C_PTR_W'(1) : rptr_q;
    cnt_d      = cnt_q;
    if (w_push && !w_pop) cnt_d = cnt_q + (C_PTR_W+1)'(1);
    if (!w_push && w_pop) cnt_d = cnt_q - (C_PTR_W+1)'(1);

    if (w_start) begin
      len_d     = len;
      src_d     = src_addr;
      dst_d     = dst_addr;
      src_inc_d = src_inc;
      dst_inc_d = dst_inc;
      busy_d    = 1'b1;
      err_d     = 1'b0;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
    end else if (w_bad) begin
      err_d = 1'b1;
    end

    // Read engine: one outstanding read, gated by FIFO space.
    case (rd_state_q)
      RD_IDLE: begin
        if (w_start) begin
          if (len != '0) begin
            rd_state_d = RD_AR;
            arvalid_d  = 1'b1;
            araddr_d   = src_addr;
          end
        end else if (busy_q && !err_d && (rd_cnt_d < w_len) && (cnt_d < C_DEPTH)) begin
          rd_state_d = RD_AR;
          arvalid_d  = 1'b1;
          araddr_d   = f_addr(src_q, src_inc_q, rd_cnt_d);
        end
      end
      RD_AR: begin
        if (ARREADY) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RD_R;
        end
      end
      RD_R: begin
        if (RVALID) begin
          rready_d = 1'b0;
          if (!err_d && (rd_cnt_d < w_len) && (cnt_d < C_DEPTH)) begin
            rd_state_d = RD_AR;
            arvalid_d  = 1'b1;
            araddr_d   = f_addr(src_q, src_inc_q, rd_cnt_d);
          end else begin
            rd_state_d = RD_IDLE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // Write engine: AW and W raised together, each dropped at its own handshake.
    case (wr_state_q)
      WR_IDLE: begin
        if (busy_q && !err_d && (wr_cnt_d < w_len) && (cnt_d != '0)) begin
          wr_state_d = WR_AWW;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = f_addr(dst_q, dst_inc_q, wr_cnt_d);
          wdata_d    = w_head;
        end
      end
      WR_AWW: begin
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          wr_state_d = WR_B;
          bready_d   = 1'b1;
        end
      end
      WR_B: begin
        if (BVALID) begin
          bready_d = 1'b0;
          if (!err_d && (wr_cnt_d < w_len) && (cnt_d != '0)) begin
            wr_state_d = WR_AWW;
            awvalid_d  = 1'b1;
            wvalid_d   = 1'b1;
            awaddr_d   = f_addr(dst_q, dst_inc_q, wr_cnt_d);
            wdata_d    = w_head;
          end else begin
            wr_state_d = WR_IDLE;
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // Completion: last write acknowledged, or an abort once both engines idle.
    if (busy_q && ((wr_cnt_d == w_len) ||
                   (err_d && (rd_state_d == RD_IDLE) && (wr_state_d == WR_IDLE)))) begin
      done_d     = 1'b1;
      busy_d     = 1'b0;
      rd_state_d = RD_IDLE;
      wr_state_d = WR_IDLE;
      arvalid_d  = 1'b0;
      rready_d   = 1'b0;
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      bready_d   = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      src_inc_q  <= 1'b0;
      dst_inc_q  <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      bready_q   <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      src_inc_q  <= src_inc_d;
      dst_inc_q  <= dst_inc_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      bready_q   <= bready_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers and count only.
  always_ff @(posedge clk) begin
    if (w_push) mem[wptr_q] <= RDATA;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = err_q;
  assign ARVALID = arvalid_q;
  assign ARADDR  = araddr_q;
  assign RREADY  = rready_q;
  assign AWVALID = awvalid_q;
  assign AWADDR  = awaddr_q;
  assign WVALID  = wvalid_q;
  assign WDATA   = wdata_q;
  assign BREADY  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_master_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_master_mc
// Description : Directed self-checking bench for dma_master_mc with a small
//               reactive AXI-lite slave (response one cycle after READY).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_master_mc;

  logic        clk, rst_n, start, src_inc, dst_inc;
  logic [7:0]  len;
  logic [31:0] src_addr, dst_addr;
  logic        busy, done, error;
  logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY;
  logic        BVALID, BREADY;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [1:0]  RRESP, BRESP;

  logic stall;
  int   bad_b;
  int   checks, errors;

  // Slave-side logs and counters
  logic [31:0] ar_log [64];
  logic [31:0] aw_log [64];
  logic [31:0] w_log  [64];
  logic [31:0] rd_addr_l;
  int ar_n, aw_n, w_n, r_n, b_n, done_n, v_n;
  int ab, awb, wb, rb, bb, db, vb;

  dma_master_mc #(.DATA_W(32), .ADDR_W(32), .LEN_W(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .src_addr(src_addr), .dst_addr(dst_addr), .src_inc(src_inc), .dst_inc(dst_inc),
    .busy(busy), .done(done), .error(error),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ARREADY = 1'b1;
  assign AWREADY = ~stall;
  assign WREADY  = ~stall;
  assign RRESP   = 2'b00;

  function automatic logic [31:0] gen(input logic [31:0] a, input int k);
    return 32'hD000_0000 ^ (32'(k) << 16) ^ a;
  endfunction

  // Response channels: VALID rises the cycle after READY is first seen.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      BVALID <= 1'b0;
      BRESP  <= 2'b00;
    end else begin
      if (RVALID && RREADY) RVALID <= 1'b0;
      else if (RREADY && !RVALID) begin
        RVALID <= 1'b1;
        RDATA  <= gen(rd_addr_l, r_n);
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      else if (BREADY && !BVALID) begin
        BVALID <= 1'b1;
        BRESP  <= (b_n == bad_b) ? 2'd2 : 2'd0;
      end
    end
  end

  // Handshake logging and event counters
  initial begin
    ar_n = 0; aw_n = 0; w_n = 0; r_n = 0; b_n = 0; done_n = 0; v_n = 0; rd_addr_l = '0;
  end
  always @(posedge clk) begin
    if (ARVALID && ARREADY) begin ar_log[ar_n] <= ARADDR; rd_addr_l <= ARADDR; ar_n <= ar_n + 1; end
    if (AWVALID && AWREADY) begin aw_log[aw_n] <= AWADDR; aw_n <= aw_n + 1; end
    if (WVALID && WREADY)   begin w_log[w_n] <= WDATA; w_n <= w_n + 1; end
    if (RVALID && RREADY) r_n <= r_n + 1;
    if (BVALID && BREADY) b_n <= b_n + 1;
    if (done) done_n <= done_n + 1;
    if (ARVALID || AWVALID || WVALID) v_n <= v_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] status();
    return {busy, ARVALID, RREADY, AWVALID, WVALID, BREADY, done};
  endfunction

  task automatic snap();
    ab = ar_n; awb = aw_n; wb = w_n; rb = r_n; bb = b_n; db = done_n; vb = v_n;
  endtask

  // Pulse start for one cycle; returns at the middle of cycle 1.
  task automatic kick(input logic [7:0] l, input logic [31:0] s, input logic [31:0] d,
                      input logic si, input logic di);
    @(negedge clk);
    len = l; src_addr = s; dst_addr = d; src_inc = si; dst_inc = di; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, 64'(seen), 64'(1));
  endtask

  task automatic check_copy(input string t, input int n, input logic [31:0] s,
                            input logic [31:0] d, input logic si, input logic di);
    logic [31:0] ea, ed;
    for (int i = 0; i < n; i++) begin
      ea = s + (si ? 32'(4 * i) : 32'd0);
      ed = d + (di ? 32'(4 * i) : 32'd0);
      chk($sformatf("%s_araddr%0d", t, i), 64'(ar_log[ab + i]), 64'(ea));
      chk($sformatf("%s_awaddr%0d", t, i), 64'(aw_log[awb + i]), 64'(ed));
      chk($sformatf("%s_wdata%0d", t, i), 64'(w_log[wb + i]), 64'(gen(ea, rb + i)));
    end
    chk($sformatf("%s_nar", t), 64'(ar_n - ab), 64'(n));
    chk($sformatf("%s_naw", t), 64'(aw_n - awb), 64'(n));
    chk($sformatf("%s_ndone", t), 64'(done_n - db), 64'(1));
    chk($sformatf("%s_busy_after", t), 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] exp_t1 [8];

  initial begin
    checks = 0; errors = 0; stall = 1'b0; bad_b = -1;
    rst_n = 1'b0; start = 1'b0; len = '0; src_addr = '0; dst_addr = '0;
    src_inc = 1'b0; dst_inc = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({status(), error}), 64'(0));
    chk("reset_addr", {ARADDR, AWADDR}, 64'(0));
    rst_n = 1'b1;

    // Single word: cycle-exact timing against a zero-wait slave
    exp_t1[0] = 7'b1100000; exp_t1[1] = 7'b1010000; exp_t1[2] = 7'b1010000;
    exp_t1[3] = 7'b1001100; exp_t1[4] = 7'b1000010; exp_t1[5] = 7'b1000010;
    exp_t1[6] = 7'b0000001; exp_t1[7] = 7'b0000000;
    snap();
    kick(8'd1, 32'h100, 32'h200, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t1_status_cyc%0d", c + 1), 64'(status()), 64'(exp_t1[c]));
      if (c == 0) chk("t1_araddr", 64'(ARADDR), 64'(32'h100));
      if (c == 2) chk("t1_rvalid", 64'(RVALID), 64'(1));
      if (c == 3) begin
        chk("t1_awaddr", 64'(AWADDR), 64'(32'h200));
        chk("t1_wdata", 64'(WDATA), 64'(gen(32'h100, rb)));
      end
      @(negedge clk);
    end

    // Basic copy, both sides incrementing
    snap();
    kick(8'd4, 32'h1000, 32'h2000, 1'b1, 1'b1);
    wait_done(200, "t2_done");
    @(negedge clk);
    check_copy("t2", 4, 32'h1000, 32'h2000, 1'b1, 1'b1);

    // Fixed source address
    snap();
    kick(8'd3, 32'h4000, 32'h3000, 1'b0, 1'b1);
    wait_done(200, "t3_done");
    @(negedge clk);
    check_copy("t3", 3, 32'h4000, 32'h3000, 1'b0, 1'b1);

    // Write-side backpressure fills the 2-entry FIFO
    snap();
    stall = 1'b1;
    kick(8'd5, 32'h5000, 32'h6000, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("bp_reads", 64'(r_n - rb), 64'(2));
    chk("bp_ars", 64'(ar_n - ab), 64'(2));
    chk("bp_arvalid", 64'(ARVALID), 64'(0));
    chk("bp_awvalid_held", 64'(AWVALID), 64'(1));
    chk("bp_wdata_held", 64'(WDATA), 64'(gen(32'h5000, rb)));
    stall = 1'b0;
    wait_done(300, "bp_done");
    @(negedge clk);
    check_copy("bp", 5, 32'h5000, 32'h6000, 1'b1, 1'b1);

    // Zero length: busy for one cycle, then done, no bus activity
    snap();
    kick(8'd0, 32'h1234, 32'h5678, 1'b1, 1'b1);
    chk("len0_cyc1", 64'(status()), 64'(7'b1000000));
    @(negedge clk);
    chk("len0_cyc2", 64'(status()), 64'(7'b0000001));
    @(negedge clk);
    chk("len0_cyc3", 64'(status()), 64'(7'b0000000));
    chk("len0_novalid", 64'(v_n - vb), 64'(0));
    chk("len0_ndone", 64'(done_n - db), 64'(1));

    // start while busy is ignored
    snap();
    kick(8'd2, 32'h7000, 32'h7100, 1'b1, 1'b1);
    @(negedge clk);
    len = 8'd9; src_addr = 32'h9000; dst_addr = 32'h9100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, "mid_done");
    @(negedge clk);
    repeat (3) @(negedge clk);
    check_copy("mid", 2, 32'h7000, 32'h7100, 1'b1, 1'b1);

    // Destination address wraps modulo 2^32
    snap();
    kick(8'd2, 32'h8000, 32'hFFFF_FFFC, 1'b1, 1'b1);
    wait_done(200, "wrap_done");
    @(negedge clk);
    check_copy("wrap", 2, 32'h8000, 32'hFFFF_FFFC, 1'b1, 1'b1);
    chk("wrap_aw1_zero", 64'(aw_log[awb + 1]), 64'(0));

    // Bad write response on word 1 of 4
    snap();
    bad_b = bb + 1;
    kick(8'd4, 32'hE000, 32'hF000, 1'b1, 1'b1);
    wait_done(300, "abort_done");
`ifdef DMA_RESP_CHECK_EN
    chk("abort_error_at_done", 64'(error), 64'(1));
    @(negedge clk);
    bad_b = -1;
    chk("abort_naw", 64'(aw_n - awb), 64'(2));
    chk("abort_ndone", 64'(done_n - db), 64'(1));
    chk("abort_error_hold", 64'(error), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    snap();
    kick(8'd1, 32'hE100, 32'hF100, 1'b1, 1'b1);
    chk("abort_error_clr", 64'(error), 64'(0));
    wait_done(200, "post_abort_done");
    @(negedge clk);
    check_copy("post_abort", 1, 32'hE100, 32'hF100, 1'b1, 1'b1);
`else
    chk("noabort_error", 64'(error), 64'(0));
    @(negedge clk);
    bad_b = -1;
    check_copy("noabort", 4, 32'hE000, 32'hF000, 1'b1, 1'b1);
`endif

    // Asynchronous reset in the middle of a transfer
    snap();
    kick(8'd4, 32'hA000, 32'hB000, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 64'({status(), error}), 64'(0));
    chk("arst_addr", {ARADDR, AWADDR}, 64'(0));
    chk("arst_wdata", 64'(WDATA), 64'(0));
    repeat (3) @(negedge clk);
    chk("arst_nodone", 64'(done_n - db), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    kick(8'd1, 32'hC000, 32'hD000, 1'b1, 1'b1);
    wait_done(200, "recover_done");
    @(negedge clk);
    check_copy("recover", 1, 32'hC000, 32'hD000, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
